delay_var: RTL and testbench

- Runtime-programmable, clock-enabled delay line with per-sample valid tracking and synchronous flush.
- Next generation of the fixed-latency pipeline delay. Used wherever a data path must be re-aligned to a control path whose latency is set by configuration rather than at synthesis, e.g. between pixel/timing generators and downstream logic.
- Implemented as a MAX_DEL-stage shift register. Output is selected from a tap chosen by a registered delay value.

---
 rtl/delay_var.sv | 104 ++++++++++
 tb/tb_delay_var.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/delay_var.sv
// Programmable delay line: taps a MAX_DEL-stage shift register at a runtime-selected depth.
// Latency: del_cur enabled edges from capture to dout, counting only ce=1 edges.
// Backpressure: none; ce=0 freezes the line, and no ready signal is returned.
module delay_var #(
    parameter int WIDTH   = 8,
    parameter int MAX_DEL = 16,
    parameter int DEL_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             flush,
    input  logic             del_ld,
    input  logic [DEL_W-1:0] del,
    input  logic             din_vld,
    input  logic [WIDTH-1:0] din,
    output logic             dout_vld,
    output logic [WIDTH-1:0] dout,
    output logic [DEL_W-1:0] del_cur,
    output logic [DEL_W-1:0] fill
);

    localparam logic [DEL_W-1:0] MAX_DEL_W = DEL_W'(MAX_DEL);

    logic [WIDTH-1:0] stg_dat_q [MAX_DEL];
    logic [WIDTH-1:0] stg_dat_d [MAX_DEL];
    logic             stg_vld_q [MAX_DEL];
    logic             stg_vld_d [MAX_DEL];
    logic [DEL_W-1:0] del_q, del_d;
    logic [DEL_W-1:0] fill_q, fill_d;
    logic [DEL_W-1:0] tap;

    // Zero would select a stage that does not exist, so it maps to the shortest delay.
    function automatic logic [DEL_W-1:0] clamp_del(input logic [DEL_W-1:0] d);
        if (d == '0)
            return DEL_W'(1);
        else if (d > MAX_DEL_W)
            return MAX_DEL_W;
        else
            return d;
    endfunction

    always_comb begin
        stg_dat_d = stg_dat_q;
        stg_vld_d = stg_vld_q;
        fill_d    = fill_q;
        del_d     = del_q;

        if (flush) begin
            for (int i = 0; i < MAX_DEL; i++) begin
                stg_dat_d[i] = '0;
                stg_vld_d[i] = 1'b0;
            end
            fill_d = '0;
        end else if (ce) begin
            stg_dat_d[0] = din;
            stg_vld_d[0] = din_vld;
            for (int i = 1; i < MAX_DEL; i++) begin
                stg_dat_d[i] = stg_dat_q[i-1];
                stg_vld_d[i] = stg_vld_q[i-1];
            end
            if (fill_q != MAX_DEL_W)
                fill_d = fill_q + DEL_W'(1);
        end

        // Delay select is loaded regardless of ce or flush.
        if (del_ld)
            del_d = clamp_del(del);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_DEL; i++) begin
                stg_dat_q[i] <= '0;
                stg_vld_q[i] <= 1'b0;
            end
            fill_q <= '0;
            del_q  <= MAX_DEL_W;
        end else begin
            stg_dat_q <= stg_dat_d;
            stg_vld_q <= stg_vld_d;
            fill_q    <= fill_d;
            del_q     <= del_d;
        end
    end

    // del_q is always in 1..MAX_DEL, so exactly one stage matches the tap.
    assign tap = del_q - DEL_W'(1);

    always_comb begin
        dout     = '0;
        dout_vld = 1'b0;
        for (int i = 0; i < MAX_DEL; i++) begin
            if (tap == DEL_W'(i)) begin
                dout     = stg_dat_q[i];
                dout_vld = stg_vld_q[i];
            end
        end
    end

    assign del_cur = del_q;
    assign fill    = fill_q;

endmodule

// File: tb/tb_delay_var.sv
// Bench for delay_var: directed scenarios plus a random soak against a history-queue model.
module tb_delay_var;

    localparam int WIDTH   = 8;
    localparam int MAX_DEL = 16;
    localparam int DEL_W   = 5;

    logic             clk = 1'b0;
    logic             rst, ce, flush, del_ld, din_vld;
    logic [DEL_W-1:0] del;
    logic [WIDTH-1:0] din;
    logic             dout_vld;
    logic [WIDTH-1:0] dout;
    logic [DEL_W-1:0] del_cur;
    logic [DEL_W-1:0] fill;

    delay_var #(.WIDTH(WIDTH), .MAX_DEL(MAX_DEL), .DEL_W(DEL_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .flush   (flush),
        .del_ld  (del_ld),
        .del     (del),
        .din_vld (din_vld),
        .din     (din),
        .dout_vld(dout_vld),
        .dout    (dout),
        .del_cur (del_cur),
        .fill    (fill)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    // Model: newest enabled sample at index 0, {vld, data}; emptied by rst/flush.
    logic [WIDTH:0] hist[$];
    int             m_del = MAX_DEL;

    function automatic int clamp(input int d);
        if (d == 0) return 1;
        if (d > MAX_DEL) return MAX_DEL;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_model();
        logic [WIDTH:0] e;
        int             f;
        e = '0;
        if (hist.size() >= m_del) e = hist[m_del-1];
        f = (hist.size() > MAX_DEL) ? MAX_DEL : hist.size();
        chk("dout",     32'(dout),     32'(e[WIDTH-1:0]));
        chk("dout_vld", 32'(dout_vld), 32'(e[WIDTH]));
        chk("del_cur",  32'(del_cur),  32'(m_del));
        chk("fill",     32'(fill),     32'(f));
    endtask

    task automatic cycle(input logic i_rst, input logic i_ce, input logic i_flush,
                         input logic i_ld, input int i_del, input logic i_vld,
                         input logic [WIDTH-1:0] i_din);
        rst     = i_rst;
        ce      = i_ce;
        flush   = i_flush;
        del_ld  = i_ld;
        del     = DEL_W'(i_del);
        din_vld = i_vld;
        din     = i_din;
        @(posedge clk);
        if (i_rst) begin
            hist.delete();
            m_del = MAX_DEL;
        end else begin
            if (i_flush) begin
                hist.delete();
            end else if (i_ce) begin
                hist.push_front({i_vld, i_din});
                if (hist.size() > MAX_DEL) void'(hist.pop_back());
            end
            if (i_ld) m_del = clamp(int'(del));
        end
        #1;
        check_model();
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; flush = 1'b0; del_ld = 1'b0;
        del = '0; din_vld = 1'b0; din = '0;

        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 1, 8'hAA);
        chk("rst_dout",    32'(dout),     32'd0);
        chk("rst_vld",     32'(dout_vld), 32'd0);
        chk("rst_del_cur", 32'(del_cur),  32'd16);
        chk("rst_fill",    32'(fill),     32'd0);

        // Counting stream at delay 3.
        cycle(0, 0, 0, 1, 3, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            cycle(0, 1, 0, 0, 0, 1, WIDTH'(i));
            if (i == 3) chk("d3_first", 32'(dout), 32'd1);
        end
        chk("fill_sat", 32'(fill), 32'(MAX_DEL));

        // Alternating ce at delay 2.
        cycle(0, 0, 0, 1, 2, 0, 0);
        for (int i = 0; i < 24; i++)
            cycle(0, (i % 2) == 0, 0, 0, 0, 1'($urandom), WIDTH'($urandom));

        // Delay 4, then shrink to 2, then grow to 8 (history reused).
        cycle(0, 1, 0, 1, 4, 1, WIDTH'($urandom));
        for (int i = 0; i < 12; i++) cycle(0, 1, 0, 0, 0, 1, WIDTH'($urandom));
        cycle(0, 0, 0, 1, 2, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 1, WIDTH'($urandom));
        cycle(0, 0, 0, 1, 8, 0, 0);
        chk("grow_vld", 32'(dout_vld), 32'd1);
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0, 0, 1, WIDTH'($urandom));

        // Clamp boundaries.
        cycle(0, 1, 0, 1, 0, 1, WIDTH'($urandom));
        chk("clamp_lo", 32'(del_cur), 32'd1);
        cycle(0, 1, 0, 1, 31, 1, WIDTH'($urandom));
        chk("clamp_hi", 32'(del_cur), 32'd16);
        cycle(0, 1, 0, 1, 17, 1, WIDTH'($urandom));
        chk("clamp_17", 32'(del_cur), 32'd16);

        // Alternating din_vld at delay 5.
        cycle(0, 1, 0, 1, 5, 1, WIDTH'($urandom));
        for (int i = 0; i < 20; i++) cycle(0, 1, 0, 0, 0, (i % 2) == 0, WIDTH'($urandom));

        // Flush together with a delay load.
        cycle(0, 1, 1, 1, 6, 1, 8'h55);
        chk("flush_dout", 32'(dout),     32'd0);
        chk("flush_vld",  32'(dout_vld), 32'd0);
        chk("flush_fill", 32'(fill),     32'd0);
        chk("flush_del",  32'(del_cur),  32'd6);
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0, 0, 1, WIDTH'(8'h60 + i));

        // Reset mid-stream restores the maximum delay.
        cycle(1, 1, 0, 0, 0, 1, WIDTH'($urandom));
        chk("rst_mid_del", 32'(del_cur), 32'd16);
        chk("rst_mid_vld", 32'(dout_vld), 32'd0);

        // Random soak.
        for (int i = 0; i < 500; i++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 14) == 0),
                  int'($urandom_range(0, 31)),
                  1'($urandom),
                  WIDTH'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
